// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port pipelined RAM.
package ram_pkg;

  // Read-during-write behaviour of a write request's response.
  typedef enum logic [1:0] {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST,
    RDW_NO_CHANGE
  } rdw_mode_e;

  // Widest word the merge helper handles; wider words are rejected at elaboration.
  localparam int MERGE_W = 1024;

  // Byte-lane merge: lanes with be set take new_word, all others keep old_word.
  // Callers zero-extend narrower words and enables, so the unused lanes stay disabled.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0] old_word,
    input logic [MERGE_W-1:0] new_word,
    input logic [MERGE_W-1:0] be,
    input int                 byte_width
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    if (byte_width > 0) begin
      for (int i = 0; i < MERGE_W; i++) begin
        if (be[i / byte_width]) begin
          res[i] = new_word[i];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rsp_pipe.sv
// Response delay line: DEPTH register stages of valid/data/oor.
// A stage loads data only when its valid input is set, so data holds between responses.
// DEPTH = 0 is a plain wire-through.
module ram_rsp_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             oor_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             oor_o
);

  if (DEPTH == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
    assign oor_o   = oor_i;
  end else begin : g_stages
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0]            o_q;

    // Shift valid every cycle; move data/oor only alongside a valid response.
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        v_q <= '0;
        d_q <= '0;
        o_q <= '0;
      end else begin
        v_q[0] <= valid_i;
        if (valid_i) begin
          d_q[0] <= data_i;
          o_q[0] <= oor_i;
        end
        for (int i = 1; i < DEPTH; i++) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            d_q[i] <= d_q[i-1];
            o_q[i] <= o_q[i-1];
          end
        end
      end
    end

    assign valid_o = v_q[DEPTH-1];
    assign data_o  = d_q[DEPTH-1];
    assign oor_o   = o_q[DEPTH-1];
  end

endmodule

// File: rtl/ram_s1p1c_pipe.sv
// Single-port, single-clock RAM with byte-lane writes, a request/valid
// response path of fixed latency and selectable read-during-write behaviour.
module ram_s1p1c_pipe
  import ram_pkg::*;
#(
  parameter int        WORD_WIDTH    = 32,
  parameter int        WORD_COUNT    = 256,
  parameter int        BYTE_WIDTH    = 8,
  parameter int        READ_LATENCY  = 1,
  parameter rdw_mode_e RDW_MODE      = RDW_READ_FIRST,
  parameter bit        INIT_FILE_BIN = 1'b0,
  parameter string     INIT_FILE     = "",
  localparam int       ADDR_WIDTH    = $clog2(WORD_COUNT),
  localparam int       BE_WIDTH      = WORD_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  rvalid_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  oor_o
);

  // One extra bit so the depth itself is representable for power-of-two sizes.
  localparam logic [ADDR_WIDTH:0] WORD_COUNT_L = (ADDR_WIDTH + 1)'(WORD_COUNT);

  if ((WORD_WIDTH % BYTE_WIDTH) != 0) begin : g_err_width
    $error("ram_s1p1c_pipe: WORD_WIDTH (%0d) is not a multiple of BYTE_WIDTH (%0d)",
           WORD_WIDTH, BYTE_WIDTH);
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_err_latency
    $error("ram_s1p1c_pipe: READ_LATENCY (%0d) outside 1..4", READ_LATENCY);
  end
  if (WORD_COUNT < 2) begin : g_err_depth
    $error("ram_s1p1c_pipe: WORD_COUNT (%0d) must be at least 2", WORD_COUNT);
  end
  if (WORD_WIDTH > MERGE_W) begin : g_err_merge
    $error("ram_s1p1c_pipe: WORD_WIDTH (%0d) exceeds merge helper width", WORD_WIDTH);
  end

  logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

  // Init file report; contents are never touched by reset.
  initial begin
    if (INIT_FILE != "") begin
      $display("ram_s1p1c_pipe: init file %s (%s)", INIT_FILE,
               INIT_FILE_BIN ? "binary" : "hex");
    end
  end

  logic                  in_range;
  logic                  wr_en;
  logic                  rsp_fire;
  logic [WORD_WIDTH-1:0] old_word;
  logic [WORD_WIDTH-1:0] merged_word;
  logic [WORD_WIDTH-1:0] rsp_data;
  logic [MERGE_W-1:0]    merged_full;
  logic                  unused_merge;

  // Address decode, lane merge and response selection for the current request.
  always_comb begin
    in_range    = ({1'b0, addr_i} < WORD_COUNT_L);
    old_word    = in_range ? mem[addr_i] : '0;
    merged_full = byte_merge(MERGE_W'(old_word), MERGE_W'(data_i), MERGE_W'(be_i), BYTE_WIDTH);
    merged_word = merged_full[WORD_WIDTH-1:0];
    wr_en       = req_i && we_i && in_range;
    rsp_fire    = req_i && (!we_i || (RDW_MODE != RDW_NO_CHANGE));
    if (!in_range) begin
      rsp_data = '0;
    end else if (we_i && (RDW_MODE == RDW_WRITE_FIRST)) begin
      rsp_data = merged_word;
    end else begin
      rsp_data = old_word;
    end
  end

  assign unused_merge = ^merged_full;

  // Per-lane memory write; requests coinciding with reset are dropped.
  always_ff @(posedge clk_i) begin
    if (rstn_i && wr_en) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (be_i[k]) begin
          mem[addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic                  s0_valid;
  logic [WORD_WIDTH-1:0] s0_data;
  logic                  s0_oor;

  // Stage 0: capture the response at the request edge, holding data when idle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_oor   <= 1'b0;
    end else begin
      s0_valid <= rsp_fire;
      if (rsp_fire) begin
        s0_data <= rsp_data;
        s0_oor  <= !in_range;
      end
    end
  end

  ram_rsp_pipe #(
    .DEPTH (READ_LATENCY - 1),
    .WIDTH (WORD_WIDTH)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (s0_valid),
    .data_i  (s0_data),
    .oor_i   (s0_oor),
    .valid_o (rvalid_o),
    .data_o  (data_o),
    .oor_o   (oor_o)
  );

  // Input sanity outside reset.
  a_req_known : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !$isunknown(req_i));
  a_ctrl_known : assert property (@(posedge clk_i) disable iff (!rstn_i)
    req_i |-> !$isunknown({we_i, addr_i}));
  a_wdata_known : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (req_i && we_i) |-> !$isunknown({be_i, data_i}));

endmodule

// File: tb/tb_ram_s1p1c_pipe.sv
// Scoreboard bench: three RAM configurations driven by directed vectors;
// a negedge monitor pops expected responses (data, oor, arrival cycle).
module tb_ram_s1p1c_pipe;
  import ram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        rstn   [3];
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [7:0]  addr   [3];
  logic [31:0] din    [3];
  logic        rvalid [3];
  logic [31:0] dout   [3];
  logic        oor    [3];

  typedef struct {
    logic [31:0] data;
    logic        oor;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t sbq [3][$];

  // u0: latency 3, read-first, 256 words
  ram_s1p1c_pipe #(.WORD_WIDTH(32), .WORD_COUNT(256), .BYTE_WIDTH(8),
                   .READ_LATENCY(3), .RDW_MODE(RDW_READ_FIRST)) u0 (
    .clk_i(clk), .rstn_i(rstn[0]), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .data_i(din[0]), .rvalid_o(rvalid[0]), .data_o(dout[0]), .oor_o(oor[0]));

  // u1: latency 2, write-first, 256 words
  ram_s1p1c_pipe #(.WORD_WIDTH(32), .WORD_COUNT(256), .BYTE_WIDTH(8),
                   .READ_LATENCY(2), .RDW_MODE(RDW_WRITE_FIRST)) u1 (
    .clk_i(clk), .rstn_i(rstn[1]), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .data_i(din[1]), .rvalid_o(rvalid[1]), .data_o(dout[1]), .oor_o(oor[1]));

  // u2: latency 4, no-change, 100 words
  ram_s1p1c_pipe #(.WORD_WIDTH(32), .WORD_COUNT(100), .BYTE_WIDTH(8),
                   .READ_LATENCY(4), .RDW_MODE(RDW_NO_CHANGE)) u2 (
    .clk_i(clk), .rstn_i(rstn[2]), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2][6:0]), .data_i(din[2]), .rvalid_o(rvalid[2]), .data_o(dout[2]), .oor_o(oor[2]));

  function automatic int lat(int d);
    case (d)
      0:       return 3;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One request for one cycle; optionally queue its expected response.
  task automatic op(int d, bit w, logic [3:0] b, logic [7:0] a, logic [31:0] wd,
                    bit rsp, bit chk, logic [31:0] ed, logic eo);
    exp_t e;
    @(posedge clk); #1;
    rstn[d] = 1'b1; req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; din[d] = wd;
    if (rsp) begin
      e.data = ed; e.oor = eo; e.chk = chk; e.cyc = cyc + lat(d);
      sbq[d].push_back(e);
    end
  endtask

  task automatic idle(int d, int n);
    repeat (n) begin
      @(posedge clk); #1;
      req[d] = 1'b0; we[d] = 1'b0;
    end
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    idle(d, 1);
    while (sbq[d].size() != 0 && n < 30) begin
      idle(d, 1);
      n++;
    end
    total++;
    if (sbq[d].size() != 0) begin
      bad++;
      $display("FAIL drain dut%0d: got %0d responses outstanding want 0", d, sbq[d].size());
      sbq[d].delete();
    end
  endtask

  // Monitor: every rvalid must match the head of that DUT's queue.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rvalid[d] === 1'b1) begin
        if (sbq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_rvalid dut%0d: got rvalid=1 data=%h want rvalid=0", d, dout[d]);
        end else begin
          e = sbq[d].pop_front();
          check($sformatf("latency dut%0d", d), 32'(cyc), 32'(e.cyc));
          if (e.chk) check($sformatf("data dut%0d", d), dout[d], e.data);
          check($sformatf("oor dut%0d", d), {31'd0, oor[d]}, {31'd0, e.oor});
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
      be[d] = '0; addr[d] = '0; din[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b1;
      check($sformatf("reset rvalid dut%0d", d), {31'd0, rvalid[d]}, 32'd0);
      check($sformatf("reset data dut%0d", d), dout[d], 32'd0);
      check($sformatf("reset oor dut%0d", d), {31'd0, oor[d]}, 32'd0);
    end

    // u0: latency, byte enables, read-first
    op(0, 1, 4'hF, 8'd5, 32'hDEADBEEF, 1, 0, 32'h0, 1'b0);
    op(0, 0, 4'h0, 8'd5, 32'h0,        1, 1, 32'hDEADBEEF, 1'b0);
    op(0, 1, 4'hF, 8'd7, 32'h11223344, 1, 0, 32'h0, 1'b0);
    op(0, 1, 4'h5, 8'd7, 32'hAABBCCDD, 1, 1, 32'h11223344, 1'b0);
    op(0, 0, 4'h0, 8'd7, 32'h0,        1, 1, 32'h11BB33DD, 1'b0);
    op(0, 1, 4'hF, 8'd2, 32'h0000FFFF, 1, 0, 32'h0, 1'b0);
    op(0, 1, 4'h3, 8'd2, 32'h12345678, 1, 1, 32'h0000FFFF, 1'b0);
    op(0, 0, 4'h0, 8'd2, 32'h0,        1, 1, 32'h00005678, 1'b0);
    drain(0);

    // u1: streaming, write-first, no-op write
    for (int i = 0; i < 16; i++) op(1, 1, 4'hF, 8'(i), 32'(i * 3), 1, 1, 32'(i * 3), 1'b0);
    for (int i = 0; i < 16; i++) op(1, 0, 4'h0, 8'(i), 32'h0,      1, 1, 32'(i * 3), 1'b0);
    op(1, 1, 4'hF, 8'd2, 32'h0000FFFF, 1, 1, 32'h0000FFFF, 1'b0);
    op(1, 1, 4'h3, 8'd2, 32'h12345678, 1, 1, 32'h00005678, 1'b0);
    op(1, 1, 4'h0, 8'd2, 32'hFFFFFFFF, 1, 1, 32'h00005678, 1'b0);
    op(1, 0, 4'h0, 8'd2, 32'h0,        1, 1, 32'h00005678, 1'b0);
    drain(1);

    // u2: no-change writes
    op(2, 1, 4'hF, 8'd1, 32'h000000A1, 0, 0, 32'h0, 1'b0);
    op(2, 1, 4'hF, 8'd2, 32'h0000FFFF, 0, 0, 32'h0, 1'b0);
    op(2, 0, 4'h0, 8'd2, 32'h0,        1, 1, 32'h0000FFFF, 1'b0);
    drain(2);
    op(2, 1, 4'h3, 8'd2, 32'h12345678, 0, 0, 32'h0, 1'b0);
    idle(2, 8);
    check("nochange data hold", dout[2], 32'h0000FFFF);
    op(2, 0, 4'h0, 8'd2, 32'h0, 1, 1, 32'h00005678, 1'b0);
    op(2, 0, 4'h0, 8'd1, 32'h0, 1, 1, 32'h000000A1, 1'b0);
    drain(2);

    // u2: reset with two reads in flight
    op(2, 0, 4'h0, 8'd1, 32'h0, 0, 0, 32'h0, 1'b0);
    op(2, 0, 4'h0, 8'd2, 32'h0, 0, 0, 32'h0, 1'b0);
    @(posedge clk); #1;
    req[2] = 1'b0; rstn[2] = 1'b0;
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    check("midreset rvalid", {31'd0, rvalid[2]}, 32'd0);
    check("midreset data", dout[2], 32'd0);
    idle(2, 8);
    op(2, 0, 4'h0, 8'd1, 32'h0, 1, 1, 32'h000000A1, 1'b0);
    op(2, 0, 4'h0, 8'd2, 32'h0, 1, 1, 32'h00005678, 1'b0);
    drain(2);

    // u2: out of range
    op(2, 1, 4'hF, 8'd100, 32'h000000FF, 0, 0, 32'h0, 1'b0);
    op(2, 1, 4'hF, 8'd99,  32'h00000099, 0, 0, 32'h0, 1'b0);
    op(2, 0, 4'h0, 8'd100, 32'h0, 1, 1, 32'h00000000, 1'b1);
    op(2, 0, 4'h0, 8'd99,  32'h0, 1, 1, 32'h00000099, 1'b0);
    op(2, 0, 4'h0, 8'd100, 32'h0, 1, 1, 32'h00000000, 1'b1);
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
